// File: rtl/answer_timer_ctrl.sv
// Answer-window countdown: loads seconds, counts down as two BCD digits, flags expiry.
// Optional macro TIMER_BLINK_EN blinks the display (via blank) while EXPIRED.
module answer_timer_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int BLINK_DIV    = 25000000,
  parameter int DEFAULT_SECS = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] load_secs,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic       blank,
  output logic       running,
  output logic       expired
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  // 127 selects the default; 100..126 clamp to the largest two-digit value.
  function automatic logic [6:0] eff_secs(input logic [6:0] v);
    logic [6:0] r;
    if (v == 7'd127)     r = 7'(DEFAULT_SECS);
    else if (v > 7'd99)  r = 7'd99;
    else                 r = v;
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [1:0]    r_state;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [TW-1:0] r_cnt;
  logic          r_expired;

  logic [6:0] w_load;
  logic [7:0] w_load_bcd;
  logic       w_wrap;
  logic       w_last;

  assign w_load     = eff_secs(load_secs);
  assign w_load_bcd = to_bcd(w_load);
  assign w_wrap     = (r_cnt == TW'(TICK_DIV - 1));
  assign w_last     = (r_tens == 4'd0) && (r_ones == 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (clear) begin
        r_state <= S_IDLE;
        r_tens  <= 4'd0;
        r_ones  <= 4'd0;
        r_cnt   <= '0;
      end else if (start) begin
        r_tens <= w_load_bcd[7:4];
        r_ones <= w_load_bcd[3:0];
        r_cnt  <= '0;
        if (w_load == 7'd0) begin
          r_state   <= S_EXPIRED;
          r_expired <= 1'b1;
        end else begin
          r_state <= S_RUN;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSE;
            end else if (w_wrap) begin
              r_cnt <= '0;
              if (w_last) begin
                r_ones    <= 4'd0;
                r_state   <= S_EXPIRED;
                r_expired <= 1'b1;
              end else if (r_ones == 4'd0) begin
                r_ones <= 4'd9;
                r_tens <= r_tens - 4'd1;
              end else begin
                r_ones <= r_ones - 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + TW'(1);
            end
          end
          S_PAUSE: begin
            // Tick count stays frozen so the resumed second is not shortened or lengthened.
            if (!pause) r_state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TIMER_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] r_bcnt;
  logic          r_blank;

  // Counter restarts on every entry so the first blank comes one full period in.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end else if ((r_state == S_EXPIRED) && !clear && !start) begin
      if (r_bcnt == BW'(BLINK_DIV - 1)) begin
        r_bcnt  <= '0;
        r_blank <= ~r_blank;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end else begin
      r_bcnt  <= '0;
      r_blank <= 1'b0;
    end
  end

  assign blank = r_blank;
`else
  assign blank = 1'b0;
`endif

  assign digit_tens = r_tens;
  assign digit_ones = r_ones;
  assign running    = (r_state == S_RUN);
  assign expired    = r_expired;

endmodule

// File: tb/tb_answer_timer_ctrl.sv
// Bench for answer_timer_ctrl: directed steps plus random commands against a seconds-level model.
module tb_answer_timer_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int BLINK_DIV    = 2;
  localparam int DEFAULT_SECS = 30;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSE   = 2;
  localparam int M_EXPIRED = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] load_secs;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic       blank;
  logic       running;
  logic       expired;

  int n_total = 0;
  int n_pass  = 0;

  // Model: whole seconds left, cycles into the current second, cycles spent in EXPIRED.
  int m_mode  = M_IDLE;
  int m_secs  = 0;
  int m_phase = 0;
  int m_age   = 0;
  bit m_pulse = 1'b0;

  answer_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .DEFAULT_SECS(DEFAULT_SECS)
  ) dut (
    .clock(clock), .reset(reset), .load_secs(load_secs), .start(start),
    .pause(pause), .clear(clear), .digit_tens(digit_tens), .digit_ones(digit_ones),
    .blank(blank), .running(running), .expired(expired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_update(input bit rs, input bit st, input bit ps, input bit cl,
                              input int ld);
    int v;
    m_pulse = 1'b0;
    if (rs) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_age = 0;
    end else if (cl) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else if (st) begin
      v = (ld == 127) ? DEFAULT_SECS : ((ld > 99) ? 99 : ld);
      m_secs = v; m_phase = 0; m_age = 0;
      if (v == 0) begin
        m_mode = M_EXPIRED; m_pulse = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (ps) begin
        m_mode = M_PAUSE;
      end else begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_mode = M_EXPIRED; m_pulse = 1'b1; m_age = 0;
          end
        end
      end
    end else if (m_mode == M_PAUSE) begin
      if (!ps) m_mode = M_RUN;
    end else if (m_mode == M_EXPIRED) begin
      m_age++;
    end
  endtask

  function automatic bit model_blank();
`ifdef TIMER_BLINK_EN
    return (m_mode == M_EXPIRED) && (((m_age / BLINK_DIV) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    chk("tens",    8'(digit_tens), 8'(m_secs / 10));
    chk("ones",    8'(digit_ones), 8'(m_secs % 10));
    chk("running", 8'(running),    8'(m_mode == M_RUN));
    chk("expired", 8'(expired),    8'(m_pulse));
    chk("blank",   8'(blank),      8'(model_blank()));
  endtask

  task automatic step(input bit rs, input bit st, input bit ps, input bit cl,
                      input logic [6:0] ld);
    @(negedge clock);
    reset = rs; start = st; pause = ps; clear = cl; load_secs = ld;
    @(posedge clock);
    model_update(rs, st, ps, cl, int'(ld));
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endtask

  initial begin
    int pulses;
    bit rp;
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_secs = 7'd0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    chk("rst_tens", 8'(digit_tens), 8'd0);
    chk("rst_ones", 8'(digit_ones), 8'd0);
    chk("rst_run",  8'(running), 8'd0);
    chk("rst_exp",  8'(expired), 8'd0);
    chk("rst_blank", 8'(blank), 8'd0);
    idle(2);

    // 12 seconds down to 00 with tens borrow
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd12);
    chk("ld12", {digit_tens, digit_ones}, 8'h12);
    chk("ld12_run", 8'(running), 8'd1);
    for (int i = 1; i <= 49; i++) begin
      idle(1);
      if (i == 4)  chk("t4",  {digit_tens, digit_ones}, 8'h11);
      if (i == 12) chk("t12", {digit_tens, digit_ones}, 8'h09);
      if (i == 47) begin
        chk("t47", {digit_tens, digit_ones}, 8'h01);
        chk("t47_exp", 8'(expired), 8'd0);
      end
      if (i == 48) begin
        chk("t48", {digit_tens, digit_ones}, 8'h00);
        chk("t48_exp", 8'(expired), 8'd1);
        chk("t48_run", 8'(running), 8'd0);
      end
      if (i == 49) chk("t49_exp", 8'(expired), 8'd0);
    end

    // pause mid-second: the tick count must resume where it stopped
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd5);
    chk("ld5_nopulse", 8'(expired), 8'd0);
    idle(10);
    chk("p_pre", {digit_tens, digit_ones}, 8'h03);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
      chk("p_hold", {digit_tens, digit_ones}, 8'h03);
      chk("p_run", 8'(running), 8'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      if (i == 2) chk("r2", {digit_tens, digit_ones}, 8'h02);
      if (i == 9) chk("r9", {digit_tens, digit_ones}, 8'h01);
      if (i == 10) begin
        chk("r10", {digit_tens, digit_ones}, 8'h00);
        chk("r10_exp", 8'(expired), 8'd1);
      end
    end

    // reset mid-run at 07
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd7);
    chk("ld7", {digit_tens, digit_ones}, 8'h07);
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    chk("rst_mid", {digit_tens, digit_ones}, 8'h00);
    chk("rst_mid_run", 8'(running), 8'd0);

    // load value corner cases
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd120);
    chk("ld120", {digit_tens, digit_ones}, 8'h99);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd127);
    chk("ld127", {digit_tens, digit_ones}, 8'h30);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    chk("ld0", {digit_tens, digit_ones}, 8'h00);
    chk("ld0_exp", 8'(expired), 8'd1);
    chk("ld0_run", 8'(running), 8'd0);
    idle(1);
    chk("ld0_exp2", 8'(expired), 8'd0);

    // clear beats start
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd20);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 7'd45);
    chk("clr_st", {digit_tens, digit_ones}, 8'h00);
    chk("clr_st_run", 8'(running), 8'd0);
    idle(3);
    chk("clr_hold", {digit_tens, digit_ones}, 8'h00);

    // clear in EXPIRED, then restart from EXPIRED
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd1);
    idle(4);
    chk("e1_exp", 8'(expired), 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
    chk("clr_exp_run", 8'(running), 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd3);
    chk("ld3", {digit_tens, digit_ones}, 8'h03);
    chk("ld3_run", 8'(running), 8'd1);
    pulses = int'(expired);
    for (int i = 0; i < 14; i++) begin
      idle(1);
      pulses += int'(expired);
    end
    chk("one_pulse", 8'(pulses), 8'd1);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd9);
    chk("exit_blank", 8'(blank), 8'd0);
    chk("exit_run", 8'(running), 8'd1);

    // random command mix
    rp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0), rp,
           ($urandom_range(0, 49) == 0), 7'($urandom_range(0, 127)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
